sys_bus_resp: RTL and testbench

SYS_BUS_RESP -- requirements
Module: sys_bus_resp

---
 rtl/sys_bus_resp_pkg.sv | 23 ++
 rtl/sys_bus_resp_if.sv | 14 +
 rtl/sys_bus_evt_latch.sv | 43 ++++
 rtl/sys_bus_resp.sv | 113 +++++++++++
 tb/tb_sys_bus_resp.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/sys_bus_resp_pkg.sv
// Shared constants for the system bus responder: register offsets, ID default,
// FSM encoding and the event popcount helper.
package sys_bus_resp_pkg;

  localparam logic [31:0] ID_VAL_DEF = 32'h5250_0001;

  localparam logic [19:0] OFF_ID      = 20'h00;
  localparam logic [19:0] OFF_CTRL    = 20'h04;
  localparam logic [19:0] OFF_SCRATCH = 20'h08;
  localparam logic [19:0] OFF_STAT    = 20'h0C;
  localparam logic [19:0] OFF_CNT     = 20'h10;
  localparam logic [19:0] OFF_TIMER   = 20'h14;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/sys_bus_resp_if.sv
// Request/response bus between a master and sys_bus_resp; names are from the
// responder's point of view.
interface sys_bus_resp_if;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        wen_i;
  logic        ren_i;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        ack_o;

  modport slave  (input addr_i, wdata_i, wen_i, ren_i, output rdata_o, err_o, ack_o);
  modport master (output addr_i, wdata_i, wen_i, ren_i, input rdata_o, err_o, ack_o);
endinterface

// File: rtl/sys_bus_evt_latch.sv
// Event rising-edge detector with sticky W1C status and a saturating edge counter.
module sys_bus_evt_latch
  import sys_bus_resp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  evt_i,
  input  logic        clr_i,
  input  logic [7:0]  clr_mask_i,
  input  logic        cnt_clr_i,
  output logic [7:0]  stat_o,
  output logic [15:0] cnt_o
);

  logic [7:0]  prev_q, stat_q, stat_d, rise;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] sum;
  logic        armed_q;

  // armed_q masks the first cycle after reset so already-high inputs are not edges
  assign rise   = evt_i & ~prev_q & {8{armed_q}};
  assign sum    = {1'b0, cnt_q} + 17'(popcnt8(rise));
  assign stat_d = (stat_q & ~(clr_i ? clr_mask_i : 8'h00)) | rise;
  assign cnt_d  = cnt_clr_i ? 16'h0 : (sum[16] ? 16'hFFFF : sum[15:0]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q  <= '0;
      armed_q <= 1'b0;
      stat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      prev_q  <= evt_i;
      armed_q <= 1'b1;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stat_o = stat_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/sys_bus_resp.sv
// Register-file responder: ID/CTRL/SCRATCH/EVT_STAT/EVT_CNT/TIMER behind a
// pulse-request, single-cycle-ack bus with optional read wait states.
module sys_bus_resp
  import sys_bus_resp_pkg::*;
#(
  parameter int          RD_WAIT = 0,
  parameter logic [31:0] ID_VAL  = ID_VAL_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sys_bus_resp_if.slave   bus,
  input  logic [7:0]      evt_i,
  output logic [31:0]     ctrl_o
);

  state_e      state_q, state_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [31:0] rdata_q, rdata_d, ctrl_q, scratch_q, timer_q, rd_val;
  logic        err_q, err_d, rd_hit, wr_ok, accept, wr_en;
  logic [19:0] off;
  logic [7:0]  stat;
  logic [15:0] cnt;
  logic        unused_addr;

  assign off         = {bus.addr_i[19:2], 2'b00};
  assign unused_addr = ^{bus.addr_i[31:20], bus.addr_i[1:0]};

  always_comb begin
    rd_val = '0;
    rd_hit = 1'b1;
    wr_ok  = 1'b0;
    case (off)
      OFF_ID:      rd_val = ID_VAL;
      OFF_CTRL:    begin rd_val = ctrl_q;    wr_ok = 1'b1; end
      OFF_SCRATCH: begin rd_val = scratch_q; wr_ok = 1'b1; end
      OFF_STAT:    begin rd_val = {24'h0, stat}; wr_ok = 1'b1; end
      OFF_CNT:     begin rd_val = {16'h0, cnt};  wr_ok = 1'b1; end
      OFF_TIMER:   rd_val = timer_q;
      default:     rd_hit = 1'b0;
    endcase
  end

  // a simultaneous wen/ren is a write; requests outside IDLE are dropped
  assign accept = (state_q == IDLE) && (bus.wen_i || bus.ren_i);
  assign wr_en  = accept && bus.wen_i && wr_ok;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.wen_i) begin
          rdata_d = '0;
          err_d   = !wr_ok;
          state_d = ACK;
        end else if (bus.ren_i) begin
          rdata_d = rd_val;
          err_d   = !rd_hit;
          if (RD_WAIT == 0) state_d = ACK;
          else begin
            state_d = WAIT;
            wcnt_d  = 2'(RD_WAIT - 1);
          end
        end
      end
      WAIT: begin
        if (wcnt_q == 2'd0) state_d = ACK;
        else wcnt_d = wcnt_q - 2'd1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      ctrl_q    <= '0;
      scratch_q <= '0;
      timer_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      timer_q <= timer_q + 32'd1;
      if (wr_en && off == OFF_CTRL)    ctrl_q    <= bus.wdata_i;
      if (wr_en && off == OFF_SCRATCH) scratch_q <= bus.wdata_i;
    end
  end

  sys_bus_evt_latch u_evt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .evt_i      (evt_i),
    .clr_i      (wr_en && off == OFF_STAT),
    .clr_mask_i (bus.wdata_i[7:0]),
    .cnt_clr_i  (wr_en && off == OFF_CNT),
    .stat_o     (stat),
    .cnt_o      (cnt)
  );

  assign bus.ack_o   = (state_q == ACK);
  assign bus.rdata_o = bus.ack_o ? rdata_q : 32'h0;
  assign bus.err_o   = bus.ack_o ? err_q : 1'b0;
  assign ctrl_o      = ctrl_q;

endmodule

// File: tb/tb_sys_bus_resp.sv
// Directed scoreboard bench for sys_bus_resp with RD_WAIT=2.
module tb_sys_bus_resp;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  evt = 8'h00;
  logic [31:0] ctrl;
  logic [31:0] tcnt;
  logic [7:0]  evt_issue = 8'h00;
  bit          evt_pending = 1'b0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];

  sys_bus_resp_if bus();

  sys_bus_resp #(.RD_WAIT(2)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .evt_i  (evt),
    .ctrl_o (ctrl)
  );

  always #5 clk = ~clk;

  // free-running reference for TIMER: posedges since last reset
  always @(posedge clk or posedge rst)
    if (rst) tcnt <= 32'h0;
    else     tcnt <= tcnt + 32'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                      input bit is_timer, input string tag);
    int   lat;
    exp_t e;
    @(negedge clk);
    bus.wen_i = w; bus.ren_i = r; bus.addr_i = a; bus.wdata_i = d;
    if (evt_pending) begin evt = evt_issue; evt_pending = 1'b0; end
    exp_q.push_back('{rdata: (is_timer ? tcnt : exp_rd), err: exp_err});
    @(negedge clk);
    bus.wen_i = 1'b0; bus.ren_i = 1'b0;
    lat = 1;
    while (!bus.ack_o && lat < 20) begin @(negedge clk); lat++; end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    e = exp_q.pop_front();
    chk({tag, "_rdata"}, bus.rdata_o, e.rdata);
    chk({tag, "_err"}, {31'h0, bus.err_o}, {31'h0, e.err});
    @(negedge clk);
    chk({tag, "_ack1"}, {31'h0, bus.ack_o}, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic exp_err, input string tag);
    xfer(1'b1, 1'b0, a, d, 32'h0, exp_err, 1, 1'b0, tag);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_err, input string tag);
    xfer(1'b0, 1'b1, a, 32'h0, exp_rd, exp_err, 3, 1'b0, tag);
  endtask

  initial begin
    int acks;
    logic [31:0] ack_data;
    bus.addr_i = '0; bus.wdata_i = '0; bus.wen_i = 1'b0; bus.ren_i = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'h0, bus.ack_o}, 32'h0);
    chk("rst_rdata", bus.rdata_o, 32'h0);
    chk("rst_err", {31'h0, bus.err_o}, 32'h0);
    chk("rst_ctrl", ctrl, 32'h0);
    rst = 1'b0;

    // CTRL write/readback, ID read
    wr(32'h04, 32'hDEAD_BEEF, 1'b0, "wr_ctrl");
    chk("ctrl_o", ctrl, 32'hDEAD_BEEF);
    rd(32'h04, 32'hDEAD_BEEF, 1'b0, "rd_ctrl");
    rd(32'h00, 32'h5250_0001, 1'b0, "rd_id");

    // errors: unmapped read, ID write, TIMER write
    rd(32'h40, 32'h0, 1'b1, "rd_unmapped");
    wr(32'h00, 32'h1234_5678, 1'b1, "wr_id");
    wr(32'h14, 32'h1234_5678, 1'b1, "wr_timer");
    rd(32'h00, 32'h5250_0001, 1'b0, "rd_id2");

    // address aliasing: high bits and byte offset ignored
    wr(32'hFFF0_0008, 32'h0000_1234, 1'b0, "wr_scr_alias");
    rd(32'h0000_000A, 32'h0000_1234, 1'b0, "rd_scr_alias");

    // wen+ren together behaves as write
    xfer(1'b1, 1'b1, 32'h08, 32'h55, 32'h0, 1'b0, 1, 1'b0, "wr_rd_both");
    rd(32'h08, 32'h55, 1'b0, "rd_scr");

    // events
    @(negedge clk); evt = 8'h05;
    @(negedge clk);
    rd(32'h0C, 32'h05, 1'b0, "stat_05");
    rd(32'h10, 32'h02, 1'b0, "cnt_2");
    @(negedge clk); evt = 8'h00;
    evt_issue = 8'h01; evt_pending = 1'b1;
    wr(32'h0C, 32'h01, 1'b0, "w1c_vs_set");
    rd(32'h0C, 32'h05, 1'b0, "stat_set_wins");
    rd(32'h10, 32'h03, 1'b0, "cnt_3");
    wr(32'h0C, 32'h04, 1'b0, "w1c_bit2");
    rd(32'h0C, 32'h01, 1'b0, "stat_01");
    wr(32'h10, 32'hFFFF_FFFF, 1'b0, "cnt_clr");
    rd(32'h10, 32'h00, 1'b0, "cnt_0");

    // second request during WAIT is ignored
    @(negedge clk);
    bus.ren_i = 1'b1; bus.addr_i = 32'h08;
    acks = 0; ack_data = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.ren_i = 1'b0; bus.wen_i = 1'b1; bus.addr_i = 32'h08; bus.wdata_i = 32'hAA;
      end else begin
        bus.wen_i = 1'b0;
      end
      if (bus.ack_o) begin acks++; ack_data = bus.rdata_o; end
    end
    chk("wait_ack_count", 32'(acks), 32'd1);
    chk("wait_ack_rdata", ack_data, 32'h55);
    rd(32'h08, 32'h55, 1'b0, "scr_untouched");

    // reset in WAIT with evt_i bit 0 held high
    @(negedge clk); evt = 8'h01;
    @(negedge clk);
    bus.ren_i = 1'b1; bus.addr_i = 32'h04;
    @(negedge clk);
    bus.ren_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_ctrl", ctrl, 32'h0);
    chk("async_rst_ack", {31'h0, bus.ack_o}, 32'h0);
    #1 rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.ack_o) acks++;
    end
    chk("no_ack_after_rst", 32'(acks), 32'd0);
    rd(32'h04, 32'h0, 1'b0, "rst_ctrl_reg");
    rd(32'h08, 32'h0, 1'b0, "rst_scratch");
    rd(32'h0C, 32'h0, 1'b0, "rst_stat_no_edge");
    rd(32'h10, 32'h0, 1'b0, "rst_cnt");
    xfer(1'b0, 1'b1, 32'h14, 32'h0, 32'h0, 1'b0, 3, 1'b1, "timer_a");
    repeat (5) @(negedge clk);
    xfer(1'b0, 1'b1, 32'h14, 32'h0, 32'h0, 1'b0, 3, 1'b1, "timer_b");
    @(negedge clk); evt = 8'h00;

    // saturation: 8191*8 + 6 = 65534 edges, then 8 more
    for (int i = 0; i < 8191; i++) begin
      @(negedge clk); evt = 8'hFF;
      @(negedge clk); evt = 8'h00;
    end
    @(negedge clk); evt = 8'h3F;
    @(negedge clk); evt = 8'h00;
    rd(32'h10, 32'h0000_FFFE, 1'b0, "cnt_fffe");
    @(negedge clk); evt = 8'hFF;
    @(negedge clk); evt = 8'h00;
    rd(32'h10, 32'h0000_FFFF, 1'b0, "cnt_sat");
    @(negedge clk); evt = 8'hFF;
    @(negedge clk); evt = 8'h00;
    rd(32'h10, 32'h0000_FFFF, 1'b0, "cnt_sat_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
